// File: rtl/csr_issue_serializer_if.sv
// csr_issue_serializer_if: micro-op layout plus the dispatch/ROB/CSR-unit bundle seen by the serializer.
typedef struct packed {
  logic [6:0]  opcode;
  logic [11:0] csr_addr;
  logic [4:0]  rd;
  logic [3:0]  ticket;
} to_execution;

interface csr_issue_serializer_if #(parameter int TICKET_W = 4);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  to_execution         in_data;
  logic [TICKET_W-1:0] rob_head_ticket;
  logic                commit_valid;
  logic [TICKET_W-1:0] commit_ticket;
  logic                csr_valid;
  to_execution         csr_data;
  logic                busy;
  modport master (output flush, in_valid, in_data, rob_head_ticket, commit_valid, commit_ticket,
                  input in_ready, csr_valid, csr_data, busy);
  modport slave  (input flush, in_valid, in_data, rob_head_ticket, commit_valid, commit_ticket,
                  output in_ready, csr_valid, csr_data, busy);
endinterface

// File: rtl/csr_issue_serializer.sv
// csr_issue_serializer: in-order CSR/mret/vsetvl issue, one op per commit, only at ROB head.
// Optional CSR_ISSUE_FASTPATH_EN lets an op arriving at an empty queue with a matching ticket issue next cycle.
module csr_issue_serializer #(
  parameter int DEPTH    = 2,
  parameter int TICKET_W = 4
) (
  input logic clk,
  input logic rst,
  csr_issue_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_HEAD, ISSUE, WAIT_COMMIT} state_t;
  state_t              r_state, w_state_nxt;
  to_execution         r_mem [DEPTH];
  to_execution         r_csr_data, w_head;
  logic [AW-1:0]       r_wp, r_rp;
  logic [AW:0]         r_cnt, w_cnt_nxt;
  logic [TICKET_W-1:0] r_inflight;
  logic                r_csr_valid;
  logic                w_enq, w_deq, w_commit, w_match, w_fast;
  assign w_head    = r_mem[r_rp];
  assign w_enq     = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_deq     = r_state == ISSUE;
  assign w_commit  = bus.commit_valid && bus.commit_ticket == r_inflight;
  assign w_match   = w_head.ticket == bus.rob_head_ticket;
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_deq);
`ifdef CSR_ISSUE_FASTPATH_EN
  // Queue would otherwise go idle, so the arriving op is the head and can skip WAIT_HEAD
  assign w_fast = w_enq && r_cnt == '0 && bus.in_data.ticket == bus.rob_head_ticket &&
                  (r_state == IDLE || (r_state == WAIT_COMMIT && w_commit));
`else
  assign w_fast = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:        w_state_nxt = w_enq ? WAIT_HEAD : IDLE;
      WAIT_HEAD:   w_state_nxt = w_match ? ISSUE : WAIT_HEAD;
      ISSUE:       w_state_nxt = WAIT_COMMIT;
      WAIT_COMMIT: w_state_nxt = !w_commit ? WAIT_COMMIT : (w_cnt_nxt != '0) ? WAIT_HEAD : IDLE;
      default:     w_state_nxt = IDLE;
    endcase
    if (w_fast) w_state_nxt = ISSUE;
    if (bus.flush) w_state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state     <= IDLE;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_inflight  <= '0;
      r_csr_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_csr_valid <= w_state_nxt == ISSUE;
      if (w_enq) r_wp <= r_wp + 1'b1;
      if (w_deq) begin
        r_rp       <= r_rp + 1'b1;
        r_inflight <= w_head.ticket;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wp] <= bus.in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) r_csr_data <= '0;
    else if (w_state_nxt == ISSUE) r_csr_data <= w_fast ? bus.in_data : w_head;
  end
  assign bus.in_ready  = r_cnt != (AW+1)'(DEPTH);
  assign bus.csr_valid = r_csr_valid;
  assign bus.csr_data  = r_csr_data;
  assign bus.busy      = r_cnt != '0 || r_state == ISSUE || r_state == WAIT_COMMIT;
endmodule
